// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-word signals of uart_rx
interface uart_rx_if;
    logic       ser_in;
    logic [7:0] data_out;
    logic       valid;
    logic       par_err;
    logic       frm_err;
    logic       busy;

    modport master (
        output ser_in,
        input  data_out, valid, par_err, frm_err, busy
    );

    modport slave (
        input  ser_in,
        output data_out, valid, par_err, frm_err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start, 8 data bits LSB first, even parity when UART_RX_PARITY_EN, stop
// Define UART_RX_PARITY_EN to include the parity bit in the frame; undefined gives start/8 data/stop.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic     i_clk,
    input  logic     i_rst,
    uart_rx_if.slave rx
);
    localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d, cyc_adv;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q;
    logic          valid_q, frm_err_q;
    logic          fire;
    logic          sample, bit_end;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d, par_err_q;
`endif

    // cyc_q is the offset within the current bit; it is 0 whenever the FSM sits in IDLE
    assign sample  = (cyc_q == MID);
    assign bit_end = (cyc_q == LAST);
    assign cyc_adv = bit_end ? '0 : cyc_q + ONE;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        fire    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                // The detect cycle already serves as the start sample when MID is 0
                if (!rx.ser_in) begin
                    shift_d = '0;
                    idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_d   = 1'b0;
`endif
                    cyc_d   = cyc_adv;
                    state_d = bit_end ? DATA : START;
                end
            end
            START: begin
                if (sample && rx.ser_in) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_adv;
                    if (bit_end) state_d = DATA;
                end
            end
            DATA: begin
                cyc_d = cyc_adv;
                if (sample) begin
                    shift_d[idx_q] = rx.ser_in;
`ifdef UART_RX_PARITY_EN
                    par_d = par_q ^ rx.ser_in;
`endif
                end
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cyc_d = cyc_adv;
                if (sample) par_d = par_q ^ rx.ser_in;
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                // Leave at the sample point so a following start bit can be caught at once
                cyc_d = cyc_adv;
                if (sample) begin
                    fire    = 1'b1;
                    cyc_d   = '0;
                    state_d = rx.ser_in ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cyc_d = '0;
                if (rx.ser_in) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            frm_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            valid_q   <= fire;
            frm_err_q <= fire & ~rx.ser_in;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            par_err_q <= fire & par_q;
`endif
            if (fire) data_q <= shift_q;
        end
    end

    assign rx.data_out = data_q;
    assign rx.valid    = valid_q;
    assign rx.frm_err  = frm_err_q;
    assign rx.busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx.par_err  = par_err_q;
`else
    assign rx.par_err  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 1 and 4 clocks per bit
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
    localparam int FL  = 10;
    localparam bit PEN = 1'b1;
`else
    localparam int FL  = 9;
    localparam bit PEN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  d;
        logic        pe;
        logic        fe;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;
    int   stray = 0;
    ev_t  exp1_q[$], obs1_q[$], exp4_q[$], obs4_q[$];
    ev_t  m1, m4;

    uart_rx_if if1 ();
    uart_rx_if if4 ();

    uart_rx #(.CLKS_PER_BIT(1)) dut1 (.i_clk(clk), .i_rst(rst), .rx(if1));
    uart_rx #(.CLKS_PER_BIT(4)) dut4 (.i_clk(clk), .i_rst(rst), .rx(if4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if1.valid) begin
            m1.cyc = 32'(cyc); m1.d = if1.data_out; m1.pe = if1.par_err; m1.fe = if1.frm_err;
            obs1_q.push_back(m1);
        end else if (if1.par_err || if1.frm_err) stray++;
        if (if4.valid) begin
            m4.cyc = 32'(cyc); m4.d = if4.data_out; m4.pe = if4.par_err; m4.fe = if4.frm_err;
            obs4_q.push_back(m4);
        end else if (if4.par_err || if4.frm_err) stray++;
    end

    task automatic drive(input bit four, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (four) if4.ser_in = b;
            else      if1.ser_in = b;
        end
    endtask

    task automatic send_frame(input bit four, input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic [10:0] bits;
        int cpb, t0;
        ev_t e;
        cpb = four ? 4 : 1;
        bits = '0;
        bits[8:1] = d;
        if (PEN) bits[9] = ^d ^ bad_par;
        bits[FL] = ~bad_stop;
        drive(four, 1'b0, 1);
        t0 = cyc;
        e.cyc = 32'(t0 + FL * cpb + (cpb - 1) / 2 + 1);
        e.d   = d;
        e.pe  = PEN & bad_par;
        e.fe  = bad_stop;
        if (four) exp4_q.push_back(e);
        else      exp1_q.push_back(e);
        drive(four, 1'b0, cpb - 1);
        for (int k = 1; k <= FL; k++) drive(four, bits[k], cpb);
    endtask

    task automatic test_reset();
        if1.ser_in = 1'b1;
        if4.ser_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        ncmp++;
        if (if1.data_out !== 8'h00) begin
            nfail++; $display("FAIL reset_data: got %h want 00", if1.data_out);
        end
        ncmp++;
        if ({if1.valid, if1.par_err, if1.frm_err, if1.busy} !== 4'b0000) begin
            nfail++; $display("FAIL reset_flags: got %b want 0000", {if1.valid, if1.par_err, if1.frm_err, if1.busy});
        end
        ncmp++;
        if ({if4.data_out, if4.valid, if4.par_err, if4.frm_err, if4.busy} !== 12'h000) begin
            nfail++; $display("FAIL reset_slow: got %h want 000", {if4.data_out, if4.valid, if4.par_err, if4.frm_err, if4.busy});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        ncmp++;
        if ({if1.busy, if4.busy} !== 2'b00) begin
            nfail++; $display("FAIL idle_busy: got %b want 00", {if1.busy, if4.busy});
        end
    endtask

    task automatic test_good_frame();
        ev_t e, o;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4);
        ncmp++;
        if (obs1_q.size() != exp1_q.size()) begin
            nfail++; $display("FAIL a5_count: got %0d frames want %0d", obs1_q.size(), exp1_q.size());
        end
        while (exp1_q.size() > 0 && obs1_q.size() > 0) begin
            e = exp1_q.pop_front(); o = obs1_q.pop_front(); ncmp++;
            if (o !== e) begin
                nfail++; $display("FAIL a5_frame: got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b", o.cyc, o.d, o.pe, o.fe, e.cyc, e.d, e.pe, e.fe);
            end
        end
        exp1_q.delete(); obs1_q.delete();
    endtask

    task automatic test_parity_err();
        ev_t e, o;
        send_frame(1'b0, 8'h01, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 4);
        ncmp++;
        if (obs1_q.size() != exp1_q.size()) begin
            nfail++; $display("FAIL parity_count: got %0d frames want %0d", obs1_q.size(), exp1_q.size());
        end
        while (exp1_q.size() > 0 && obs1_q.size() > 0) begin
            e = exp1_q.pop_front(); o = obs1_q.pop_front(); ncmp++;
            if (o !== e) begin
                nfail++; $display("FAIL parity_frame: got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b", o.cyc, o.d, o.pe, o.fe, e.cyc, e.d, e.pe, e.fe);
            end
        end
        exp1_q.delete(); obs1_q.delete();
    endtask

    task automatic test_break();
        ev_t e, o;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 5);
        @(negedge clk);
        ncmp++;
        if (if1.busy !== 1'b1) begin
            nfail++; $display("FAIL break_busy: got %b want 1", if1.busy);
        end
        drive(1'b0, 1'b1, 2);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4);
        ncmp++;
        if (obs1_q.size() != exp1_q.size()) begin
            nfail++; $display("FAIL break_count: got %0d frames want %0d", obs1_q.size(), exp1_q.size());
        end
        while (exp1_q.size() > 0 && obs1_q.size() > 0) begin
            e = exp1_q.pop_front(); o = obs1_q.pop_front(); ncmp++;
            if (o !== e) begin
                nfail++; $display("FAIL break_frame: got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b", o.cyc, o.d, o.pe, o.fe, e.cyc, e.d, e.pe, e.fe);
            end
        end
        exp1_q.delete(); obs1_q.delete();
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        send_frame(1'b0, 8'h0F, 1'b0, 1'b0);
        send_frame(1'b0, 8'hF0, 1'b1, 1'b0);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4);
        ncmp++;
        if (obs1_q.size() != exp1_q.size()) begin
            nfail++; $display("FAIL b2b_count: got %0d frames want %0d", obs1_q.size(), exp1_q.size());
        end
        while (exp1_q.size() > 0 && obs1_q.size() > 0) begin
            e = exp1_q.pop_front(); o = obs1_q.pop_front(); ncmp++;
            if (o !== e) begin
                nfail++; $display("FAIL b2b_frame: got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b", o.cyc, o.d, o.pe, o.fe, e.cyc, e.d, e.pe, e.fe);
            end
        end
        exp1_q.delete(); obs1_q.delete();
    endtask

    task automatic test_slow_clock();
        ev_t e, o;
        send_frame(1'b1, 8'h96, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 6);
        ncmp++;
        if (obs4_q.size() != exp4_q.size()) begin
            nfail++; $display("FAIL slow_count: got %0d frames want %0d", obs4_q.size(), exp4_q.size());
        end
        while (exp4_q.size() > 0 && obs4_q.size() > 0) begin
            e = exp4_q.pop_front(); o = obs4_q.pop_front(); ncmp++;
            if (o !== e) begin
                nfail++; $display("FAIL slow_frame: got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b", o.cyc, o.d, o.pe, o.fe, e.cyc, e.d, e.pe, e.fe);
            end
        end
        exp4_q.delete(); obs4_q.delete();
        // one-cycle glitch: low at T0, high from T0+1
        drive(1'b1, 1'b0, 1);
        drive(1'b1, 1'b1, 1);
        @(negedge clk);
        ncmp++;
        if (if4.busy !== 1'b1) begin
            nfail++; $display("FAIL glitch_busy_rise: got %b want 1", if4.busy);
        end
        repeat (2) @(negedge clk);
        ncmp++;
        if (if4.busy !== 1'b0) begin
            nfail++; $display("FAIL glitch_busy_fall: got %b want 0", if4.busy);
        end
        drive(1'b1, 1'b1, 8);
        ncmp++;
        if (obs4_q.size() != 0) begin
            nfail++; $display("FAIL glitch_valid: got %0d frames want 0", obs4_q.size());
        end
        ncmp++;
        if (if4.data_out !== 8'h96) begin
            nfail++; $display("FAIL glitch_data: got %h want 96", if4.data_out);
        end
        obs4_q.delete();
    endtask

    task automatic test_reset_abort();
        ev_t e, o;
        logic [7:0] d;
        d = 8'h33;
        drive(1'b0, 1'b0, 1);
        for (int k = 0; k < 5; k++) drive(1'b0, d[k], 1);
        #2 rst = 1'b1;
        #1;
        ncmp++;
        if ({if1.data_out, if1.valid, if1.par_err, if1.frm_err, if1.busy} !== 12'h000) begin
            nfail++; $display("FAIL abort_clear: got %h want 000", {if1.data_out, if1.valid, if1.par_err, if1.frm_err, if1.busy});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        if1.ser_in = 1'b1;
        drive(1'b0, 1'b1, 12);
        ncmp++;
        if (obs1_q.size() != 0) begin
            nfail++; $display("FAIL abort_valid: got %0d frames want 0", obs1_q.size());
        end
        obs1_q.delete();
        send_frame(1'b0, 8'h7E, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4);
        ncmp++;
        if (obs1_q.size() != exp1_q.size()) begin
            nfail++; $display("FAIL after_abort_count: got %0d frames want %0d", obs1_q.size(), exp1_q.size());
        end
        while (exp1_q.size() > 0 && obs1_q.size() > 0) begin
            e = exp1_q.pop_front(); o = obs1_q.pop_front(); ncmp++;
            if (o !== e) begin
                nfail++; $display("FAIL after_abort_frame: got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b", o.cyc, o.d, o.pe, o.fe, e.cyc, e.d, e.pe, e.fe);
            end
        end
        exp1_q.delete(); obs1_q.delete();
    endtask

    task automatic test_flags_idle();
        ncmp++;
        if (stray != 0) begin
            nfail++; $display("FAIL flags_without_valid: got %0d cycles want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_break();
        test_back_to_back();
        test_slow_clock();
        test_reset_abort();
        test_flags_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
